// File: rtl/z_seq_sub_unit.sv
`default_nettype none
// ============================================================================
// Module      : z_seq_sub_unit
// Description : Multi-cycle N-bit subtractor (diff = a - b - b_in), M bits per
//               clock, LSB chunk first, borrow carried in a register.
// Revision    : 1.0 - initial release
// ============================================================================
module z_seq_sub_unit #(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         b_in,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         b_out,
    output logic         ovf,
    output logic         zero
);

    // N must be a multiple of M with at least two chunks.
    localparam int CHUNKS = N / M;
    localparam int IDX_W  = $clog2(CHUNKS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(CHUNKS - 1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_borrow;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_diff;
    logic             r_b_out;
    logic             r_ovf;
    logic             r_zero;

    logic [M-1:0]     w_a_chunk;
    logic [M-1:0]     w_b_chunk;
    logic [M:0]       w_sum;
    logic [N-1:0]     w_diff_next;
    logic             w_last;

    // Subtraction done as an add of ~b with carry-in = ~borrow.
    always_comb begin
        w_a_chunk   = r_a[r_idx*M +: M];
        w_b_chunk   = r_b[r_idx*M +: M];
        w_sum       = {1'b0, w_a_chunk} + {1'b0, ~w_b_chunk} + {{M{1'b0}}, ~r_borrow};
        w_diff_next = r_diff;
        w_diff_next[r_idx*M +: M] = w_sum[M-1:0];
        w_last      = (r_idx == C_LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_borrow <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_b_out  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= b_in;
                        r_idx    <= '0;
                        r_diff   <= '0;
                        r_b_out  <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_zero   <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_diff   <= w_diff_next;
                    r_borrow <= ~w_sum[M];
                    r_idx    <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_b_out <= ~w_sum[M];
                        r_ovf   <= (r_a[N-1] != r_b[N-1]) && (w_diff_next[N-1] != r_a[N-1]);
                        r_zero  <= (w_diff_next == '0);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = (r_state == S_IDLE);
    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign diff  = r_diff;
    assign b_out = r_b_out;
    assign ovf   = r_ovf;
    assign zero  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_z_seq_sub_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_z_seq_sub_unit
// Description : Scoreboard bench for z_seq_sub_unit (N=16, M=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_z_seq_sub_unit;

    localparam int N = 16;
    localparam int M = 4;

    typedef struct packed {
        logic [N-1:0] d;
        logic         bo;
        logic         ov;
        logic         z;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         b_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         b_out;
    logic         ovf;
    logic         zero;

    exp_t         sb[$];
    logic [N-1:0] last_diff;
    int           n_checks;
    int           n_pass;

    z_seq_sub_unit #(.N(N), .M(M)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tbin);
        logic [N:0] full;
        exp_t e;
        full = {1'b0, ta} - {1'b0, tb_v} - {{N{1'b0}}, tbin};
        e.d  = full[N-1:0];
        e.bo = full[N];
        e.ov = (ta[N-1] != tb_v[N-1]) && (e.d[N-1] != ta[N-1]);
        e.z  = (e.d == '0);
        return e;
    endfunction

    // Results are compared whenever the DUT pulses done.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("b_out", 32'(b_out), 32'(e.bo));
                check("ovf", 32'(ovf), 32'(e.ov));
                check("zero", 32'(zero), 32'(e.z));
                last_diff = e.d;
            end
        end
    end

    // Called at the negedge right after the accepting edge; ends at the
    // negedge after the return to IDLE.
    task automatic follow_op();
        check("busy_after_accept", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_run", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("ready_return", 32'(ready), 32'd1);
        check("done_single", 32'(done), 32'd0);
        check("diff_hold", 32'(diff), 32'(last_diff));
    endtask

    task automatic wait_ready();
        int cnt;
        cnt = 0;
        while (!ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tbin);
        wait_ready();
        a     = ta;
        b     = tb_v;
        b_in  = tbin;
        start = 1'b1;
        sb.push_back(model(ta, tb_v, tbin));
        @(negedge clk);
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        b_in  = 1'($urandom);
        follow_op();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        last_diff = '0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        b_in  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_flags", {29'd0, b_out, ovf, zero}, 32'd0);

        run_op(16'h1234, 16'h0234, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0);
        run_op(16'h0005, 16'h0004, 1'b1);
        run_op(16'h7FFF, 16'hFFFF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom));
        end

        // start held through RUN/DONE with changing operands; re-issue in IDLE.
        wait_ready();
        a = 16'h00A5; b = 16'h0050; b_in = 1'b0; start = 1'b1;
        sb.push_back(model(16'h00A5, 16'h0050, 1'b0));
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000;
        follow_op();
        sb.push_back(model(16'hFFFF, 16'h0000, 1'b0));
        @(negedge clk);
        start = 1'b0;
        follow_op();

        // Abort during the second chunk.
        a = 16'h4321; b = 16'h1111; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        last_diff = '0;
        repeat (6) @(negedge clk);
        run_op(16'h0010, 16'h0001, 1'b0);

        // start coincident with rst is ignored.
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_ready", 32'(ready), 32'd1);
        check("rst_start_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/z_seq_sub_unit.md
Name: z_seq_sub_unit

Overview:
- Multi-cycle N-bit subtractor. Computes diff = a - b - b_in.
- Processes M bits per clock, least-significant chunk first, and holds the borrow in a register between chunks.
- This is the inverse-direction counterpart to the team's chunked M-bit adder stages. It serves datapaths that need wide subtraction with a small per-cycle logic footprint.
- Start/done handshake. Results are held until the next operation.

Parameters:
- N, 16, total operand width. Must be a multiple of M, and N/M >= 2.
- M, 4, chunk width processed per cycle.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; accepted only while ready=1.
- a  input  N  minuend; sampled on the accepting edge.
- b  input  N  subtrahend; sampled on the accepting edge.
- b_in  input  1  borrow-in; sampled on the accepting edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN only.
- done  output  1  one-cycle pulse; results valid while high.
- diff  output  N  difference.
- b_out  output  1  final borrow; 1 iff unsigned a < b + b_in.
- ovf  output  1  signed overflow: (a[N-1]!=b[N-1]) && (diff[N-1]!=a[N-1]).
- zero  output  1  diff == 0.

Behaviour:
- Reset values: state=IDLE, ready=1, busy=0, done=0, diff=0, b_out=0, ovf=0, zero=0. Internal chunk index and borrow register = 0, operand registers = 0.
- States and transitions:
  - IDLE -> RUN on an edge where start=1. On that edge latch a, b and borrow<=b_in, set idx<=0, clear diff.
  - RUN: each edge processes chunk idx (bits idx*M+M-1 : idx*M).
    - Chunk arithmetic: {c, r} = a_chunk + ~b_chunk + ~borrow, an (M+1)-bit result.
    - Write diff chunk <= r, borrow <= ~c, idx <= idx+1.
    - On the edge processing chunk N/M-1, go to DONE. On the same edge register b_out, ovf (from the final diff MSB) and zero (from the full final diff).
  - DONE: done=1 for exactly one cycle. Next edge -> IDLE unconditionally.
- Latency: start accepted at edge k; chunks processed on edges k+1..k+N/M; done is high in the cycle following edge k+N/M. Total latency is N/M+1 edges.
- start while RUN or DONE is ignored. Operand changes after the accepting edge have no effect.
- Back-to-back operation: start in the first IDLE cycle after done is accepted. The minimum issue interval is N/M+2 cycles.
- diff, b_out, ovf and zero hold their values in IDLE until the next accepted start. On that accepting edge, diff, b_out, ovf and zero are cleared.
- Intermediate diff chunks may be visible during RUN. They are defined as valid only while done=1.
- rst has priority over all other inputs, in any state. rst mid-operation aborts and returns all outputs to reset values on the next edge, with no done pulse. start concurrent with rst is ignored.
- Arithmetic is modulo 2^N.
- Borrow semantics are equivalent to an adder with carry-in = ~b_in on ~b. Final b_out = ~carry_out.

Test Plan:
- N=16, M=4: a=0x1234, b=0x0234, b_in=0, start at edge k -> done high only in the cycle after edge k+4; diff=0x1000, b_out=0, ovf=0, zero=0; ready returns at edge k+5.
- a=0x0000, b=0x0001, b_in=0 -> diff=0xFFFF, b_out=1, ovf=0, zero=0.
- a=0x8000, b=0x0001, b_in=0 -> diff=0x7FFF, ovf=1, b_out=0.
- a=0x0005, b=0x0004, b_in=1 -> diff=0x0000, zero=1, b_out=0, ovf=0.
- start held high through RUN while a/b change to 0xFFFF/0x0000 -> first result unaffected; a second op is accepted in the first IDLE cycle after done, and its result is correct.
- rst asserted for one edge during the second chunk -> next cycle ready=1, busy=0, done=0, diff=0; no done pulse. A following op a=0x0010, b=0x0001 gives diff=0x000F.
